// File: rtl/wb_ram_slave.sv
// Wishbone classic RAM slave: word-aligned address window, byte-lane writes,
// programmable wait states, single-cycle ACK/ERR termination.
module wb_ram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_STATES = 0
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [31:0] ADR_I,
  input  logic [3:0]  SEL_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  output logic        ERR_O
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [31:0] SPAN     = 32'(4 * DEPTH);
  localparam logic [3:0]  CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        req;
  logic [31:0] offset;
  logic        req_hit;

  logic          hit_p0;
  logic          we_p0;
  logic [3:0]    sel_p0;
  logic [31:0]   dat_p0;
  logic [AW-1:0] idx_p0;

  logic          commit;
  logic          c_hit;
  logic          c_we;
  logic [3:0]    c_sel;
  logic [31:0]   c_dat;
  logic [AW-1:0] c_idx;

  logic [31:0] mem [DEPTH];

  assign req     = CYC_I & STB_I;
  // Addresses below the base wrap to a huge offset, so one compare covers both ends.
  assign offset  = ADR_I - BASE_ADDR;
  assign req_hit = (ADR_I[1:0] == 2'b00) && (offset < SPAN);

  // Zero-wait transfers complete straight from IDLE using the live inputs;
  // otherwise the request captured at the IDLE edge is used.
  always_comb begin
    c_hit  = hit_p0;
    c_we   = we_p0;
    c_sel  = sel_p0;
    c_dat  = dat_p0;
    c_idx  = idx_p0;
    commit = 1'b0;
    if (state == IDLE) begin
      c_hit  = req_hit;
      c_we   = WE_I;
      c_sel  = SEL_I;
      c_dat  = DAT_I;
      c_idx  = offset[AW+1:2];
      commit = req && (WAIT_STATES == 0);
    end else if (state == WAIT) begin
      commit = req && (cnt == 4'd0);
    end
    if (RST_I) commit = 1'b0;
  end

  // Request capture stage
  always_ff @(posedge CLK_I) begin
    if (state == IDLE && req) begin
      hit_p0 <= req_hit;
      we_p0  <= WE_I;
      sel_p0 <= SEL_I;
      dat_p0 <= DAT_I;
      idx_p0 <= offset[AW+1:2];
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state <= IDLE;
      cnt   <= 4'd0;
      ACK_O <= 1'b0;
      ERR_O <= 1'b0;
      DAT_O <= 32'h0;
    end else begin
      ACK_O <= 1'b0;
      ERR_O <= 1'b0;
      DAT_O <= 32'h0;
      case (state)
        IDLE: begin
          if (req) begin
            if (WAIT_STATES == 0) begin
              state <= RESP;
            end else begin
              cnt   <= CNT_LOAD;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!req)                state <= IDLE;
          else if (cnt == 4'd0)    state <= RESP;
          else                     cnt   <= cnt - 4'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      // Response stage
      if (commit) begin
        ACK_O <= c_hit;
        ERR_O <= !c_hit;
        DAT_O <= (c_hit && !c_we) ? mem[c_idx] : 32'h0;
      end
    end
  end

  always_ff @(posedge CLK_I) begin
    if (commit && c_hit && c_we) begin
      for (int i = 0; i < 4; i++) begin
        if (c_sel[i]) mem[c_idx][8*i +: 8] <= c_dat[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_ram_slave.sv
// Directed bench for wb_ram_slave: one instance with no wait states, one with three.
module tb_wb_ram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc0, cyc3, stb, we;
  logic [31:0] adr, dat_w;
  logic [3:0]  sel;
  logic [31:0] dat0, dat3;
  logic        ack0, err0, ack3, err3;
  int          checks = 0;
  int          failures = 0;
  int          cycle = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  wb_ram_slave #(.BASE_ADDR(32'h0), .DEPTH(1024), .WAIT_STATES(0)) dut0 (
    .CLK_I(clk), .RST_I(rst), .CYC_I(cyc0), .STB_I(stb), .WE_I(we),
    .ADR_I(adr), .SEL_I(sel), .DAT_I(dat_w),
    .DAT_O(dat0), .ACK_O(ack0), .ERR_O(err0));

  wb_ram_slave #(.BASE_ADDR(32'h0), .DEPTH(1024), .WAIT_STATES(3)) dut3 (
    .CLK_I(clk), .RST_I(rst), .CYC_I(cyc3), .STB_I(stb), .WE_I(we),
    .ADR_I(adr), .SEL_I(sel), .DAT_I(dat_w),
    .DAT_O(dat3), .ACK_O(ack3), .ERR_O(err3));

  // Runs one transfer on the selected instance; returns at the falling edge
  // after the termination cycle, with held = termination still visible there.
  task automatic xfer(input bit inst, input bit w, input logic [31:0] a,
                      input logic [3:0] s, input logic [31:0] d,
                      output int lat, output logic [31:0] rd,
                      output logic ak, output logic er, output logic held);
    we = w; adr = a; sel = s; dat_w = d; stb = 1'b1;
    if (inst) cyc3 = 1'b1; else cyc0 = 1'b1;
    lat = 0; rd = 32'h0; ak = 1'b0; er = 1'b0; held = 1'b0;
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (inst ? (ack3 | err3) : (ack0 | err0)) begin
        lat = n;
        ak  = inst ? ack3 : ack0;
        er  = inst ? err3 : err0;
        rd  = inst ? dat3 : dat0;
        break;
      end
    end
    @(posedge clk);
    #1;
    stb = 1'b0; cyc0 = 1'b0; cyc3 = 1'b0;
    @(negedge clk);
    held = inst ? (ack3 | err3) : (ack0 | err0);
  endtask

  task automatic test_reset();
    int lat;
    rst = 1'b1; cyc0 = 1'b1; cyc3 = 1'b0; stb = 1'b1; we = 1'b0;
    adr = 32'h10; sel = 4'hF; dat_w = 32'h0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if ({ack0, err0, dat0} !== 34'h0) begin
        failures++;
        $display("FAIL reset_out0 ack=%b err=%b dat=%h required 0 0 00000000", ack0, err0, dat0);
      end
      checks++;
      if ({ack3, err3, dat3} !== 34'h0) begin
        failures++;
        $display("FAIL reset_out3 ack=%b err=%b dat=%h required 0 0 00000000", ack3, err3, dat3);
      end
    end
    rst = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (ack0) begin lat = n; break; end
    end
    checks++;
    if (lat !== 1) begin
      failures++;
      $display("FAIL reset_first_ack latency=%0d required 1", lat);
    end
    @(posedge clk);
    #1;
    stb = 1'b0; cyc0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int lat, start;
    logic [31:0] rd;
    logic ak, er, held;
    start = cycle;
    xfer(0, 1, 32'h10, 4'hF, 32'hDEAD_BEEF, lat, rd, ak, er, held);
    checks++;
    if (lat !== 1 || ak !== 1'b1 || er !== 1'b0 || held !== 1'b0) begin
      failures++;
      $display("FAIL wr0_ack lat=%0d ack=%b err=%b held=%b required 1 1 0 0", lat, ak, er, held);
    end
    xfer(0, 0, 32'h10, 4'hF, 32'h0, lat, rd, ak, er, held);
    checks++;
    if (lat !== 1 || ak !== 1'b1 || rd !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL rd0_data lat=%0d ack=%b dat=%h required 1 1 deadbeef", lat, ak, rd);
    end
    checks++;
    if (cycle - start !== 4) begin
      failures++;
      $display("FAIL wr_rd_cycles got=%0d required 4", cycle - start);
    end
  endtask

  task automatic test_byte_lanes();
    int lat;
    logic [31:0] rd;
    logic ak, er, held;
    xfer(0, 1, 32'h20, 4'hF, 32'h1122_3344, lat, rd, ak, er, held);
    xfer(0, 1, 32'h20, 4'b0101, 32'hAABB_CCDD, lat, rd, ak, er, held);
    checks++;
    if (ak !== 1'b1 || er !== 1'b0) begin
      failures++;
      $display("FAIL lane_wr_ack ack=%b err=%b required 1 0", ak, er);
    end
    xfer(0, 0, 32'h20, 4'h0, 32'h0, lat, rd, ak, er, held);
    checks++;
    if (ak !== 1'b1 || rd !== 32'h11BB_33DD) begin
      failures++;
      $display("FAIL lane_rd ack=%b dat=%h required 1 11bb33dd", ak, rd);
    end
    xfer(0, 1, 32'h20, 4'h0, 32'h0000_0000, lat, rd, ak, er, held);
    checks++;
    if (ak !== 1'b1 || er !== 1'b0) begin
      failures++;
      $display("FAIL sel0_ack ack=%b err=%b required 1 0", ak, er);
    end
    xfer(0, 0, 32'h20, 4'hF, 32'h0, lat, rd, ak, er, held);
    checks++;
    if (rd !== 32'h11BB_33DD) begin
      failures++;
      $display("FAIL sel0_keep dat=%h required 11bb33dd", rd);
    end
  endtask

  task automatic test_wait_abort();
    int lat, acks;
    logic [31:0] rd;
    logic ak, er, held;
    xfer(1, 1, 32'h10, 4'hF, 32'hDEAD_BEEF, lat, rd, ak, er, held);
    checks++;
    if (lat !== 4 || ak !== 1'b1 || held !== 1'b0) begin
      failures++;
      $display("FAIL ws3_wr lat=%0d ack=%b held=%b required 4 1 0", lat, ak, held);
    end
    xfer(1, 0, 32'h10, 4'hF, 32'h0, lat, rd, ak, er, held);
    checks++;
    if (lat !== 4 || ak !== 1'b1 || rd !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL ws3_rd lat=%0d ack=%b dat=%h required 4 1 deadbeef", lat, ak, rd);
    end
    we = 1'b1; adr = 32'h10; sel = 4'hF; dat_w = 32'h0; stb = 1'b1; cyc3 = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    stb = 1'b0;
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ack3 | err3) acks++;
    end
    cyc3 = 1'b0;
    checks++;
    if (acks !== 0) begin
      failures++;
      $display("FAIL abort_no_ack terminations=%0d required 0", acks);
    end
    xfer(1, 0, 32'h10, 4'hF, 32'h0, lat, rd, ak, er, held);
    checks++;
    if (ak !== 1'b1 || rd !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL abort_keep ack=%b dat=%h required 1 deadbeef", ak, rd);
    end
  endtask

  task automatic test_errors();
    int lat;
    logic [31:0] rd;
    logic ak, er, held;
    xfer(0, 1, 32'h12, 4'hF, 32'h0, lat, rd, ak, er, held);
    checks++;
    if (lat !== 1 || ak !== 1'b0 || er !== 1'b1 || rd !== 32'h0 || held !== 1'b0) begin
      failures++;
      $display("FAIL err_misalign lat=%0d ack=%b err=%b dat=%h held=%b required 1 0 1 0 0", lat, ak, er, rd, held);
    end
    xfer(0, 0, 32'h1000, 4'hF, 32'h0, lat, rd, ak, er, held);
    checks++;
    if (ak !== 1'b0 || er !== 1'b1 || rd !== 32'h0) begin
      failures++;
      $display("FAIL err_range_rd ack=%b err=%b dat=%h required 0 1 0", ak, er, rd);
    end
    xfer(0, 1, 32'h1000, 4'hF, 32'hFFFF_FFFF, lat, rd, ak, er, held);
    checks++;
    if (ak !== 1'b0 || er !== 1'b1) begin
      failures++;
      $display("FAIL err_range_wr ack=%b err=%b required 0 1", ak, er);
    end
    xfer(0, 0, 32'h10, 4'hF, 32'h0, lat, rd, ak, er, held);
    checks++;
    if (ak !== 1'b1 || rd !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL err_mem_keep ack=%b dat=%h required 1 deadbeef", ak, rd);
    end
    xfer(0, 0, 32'h0, 4'hF, 32'h0, lat, rd, ak, er, held);
    checks++;
    if (ak !== 1'b1 || rd !== 32'h0000_0000 && rd !== 32'h0) begin
      // word 0 was written as all ones only if a range write wrapped around
    end
    if (rd === 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL err_no_wrap dat=%h required value other than ffffffff", rd);
    end
    xfer(0, 1, 32'hFFC, 4'hF, 32'hA5A5_0FFC, lat, rd, ak, er, held);
    xfer(0, 0, 32'hFFC, 4'hF, 32'h0, lat, rd, ak, er, held);
    checks++;
    if (ak !== 1'b1 || er !== 1'b0 || rd !== 32'hA5A5_0FFC) begin
      failures++;
      $display("FAIL last_word ack=%b err=%b dat=%h required 1 0 a5a50ffc", ak, er, rd);
    end
    xfer(0, 0, 32'hFFFF_FFFC, 4'hF, 32'h0, lat, rd, ak, er, held);
    checks++;
    if (ak !== 1'b0 || er !== 1'b1) begin
      failures++;
      $display("FAIL err_top ack=%b err=%b required 0 1", ak, er);
    end
  endtask

  task automatic test_reset_mid();
    int lat, acks;
    logic [31:0] rd;
    logic ak, er, held;
    xfer(1, 1, 32'h30, 4'hF, 32'h1234_5678, lat, rd, ak, er, held);
    we = 1'b1; adr = 32'h30; sel = 4'hF; dat_w = 32'h5555_5555; stb = 1'b1; cyc3 = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    acks = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (ack3 | err3) acks++;
    end
    @(posedge clk);
    #1;
    rst = 1'b0; stb = 1'b0; cyc3 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (ack3 | err3) acks++;
    end
    checks++;
    if (acks !== 0) begin
      failures++;
      $display("FAIL rstmid_no_ack terminations=%0d required 0", acks);
    end
    xfer(1, 0, 32'h30, 4'hF, 32'h0, lat, rd, ak, er, held);
    checks++;
    if (ak !== 1'b1 || lat !== 4 || rd !== 32'h1234_5678) begin
      failures++;
      $display("FAIL rstmid_keep ack=%b lat=%0d dat=%h required 1 4 12345678", ak, lat, rd);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_wait_abort();
    test_errors();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
